vga_mixer_timing_gen: RTL and testbench
=======================================

// Module: vga_mixer_timing_gen
// PURPOSE
//   Parametrised VGA timing generator with an N-layer priority pixel mixer and per-frame
//   pairwise collision detection. Next generation of the fixed 640x480 graphics-core VGA
//   path: timing, sync polarity, pixel-clock divide, layer count and colour width are
//   generic. Sits between the framebuffer-less layer generators and the mprj_io VGA pins.
// PARAMETERS
//   H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48   horizontal timing, in pixels
//   V_ACTIVE 480, V_FP 10, V_SYNC 2,  V_BP 33   vertical timing, in lines
//   HS_POL 0, VS_POL 0   asserted level of the sync pulse (0 = active-low)
//   CLK_DIV 1            one pixel tick every CLK_DIV clocks (>=1)
//   N_LAYERS 4           layer inputs (2..8); NPAIRS = N_LAYERS*(N_LAYERS-1)/2
//   RGB_W 12             colour width; LAYER_LAT 2 layer response latency, in pixel ticks
//   BG_COLOR 12'hF00     colour driven when no layer is opaque inside the active area
// PORTS
//   clock           in  1                system clock
//   resetb          in  1                async active-low reset
//   enable          in  1                run; low = synchronous hold at origin
//   pix_ce          out 1                pixel tick strobe
//   px_x, px_y      out 11 each          current counter coordinates, valid on pix_ce
//   px_active       out 1                counters inside active area (undelayed)
//   layer_opaque    in  N_LAYERS         per-layer opaque flag, LAYER_LAT ticks after px_x/px_y
//   layer_rgb       in  N_LAYERS*RGB_W   layer i colour at [i*RGB_W +: RGB_W]
//   vga_hs, vga_vs  out 1 each           sync outputs, polarity per HS_POL/VS_POL
//   vga_de          out 1                delayed data enable
//   vga_rgb         out RGB_W            mixed pixel colour
//   frame_start     out 1                one-tick pulse on first delayed pixel (0,0)
//   collision_bits  out NPAIRS           collisions seen in last completed frame
//   collision_valid out 1                one-tick pulse when collision_bits updates
// BEHAVIOUR
//   - Reset: h=v=0, divider=0; vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, vga_rgb=0,
//     frame_start=0, collision_bits=0, collision_valid=0, pix_ce=0, accumulator=0.
//   - Divider counts 0..CLK_DIV-1; pix_ce=1 for one clock when it reaches CLK_DIV-1
//     (CLK_DIV=1: pix_ce=1 every clock while enabled).
//   - On pix_ce: h wraps H_TOTAL-1->0 (H_TOTAL=sum of H_*); v increments at h wrap and
//     wraps V_TOTAL-1->0. px_active = (h<H_ACTIVE)&&(v<V_ACTIVE).
//   - hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs likewise on v.
//   - Pipeline: hs/vs/de/frame_start delayed LAYER_LAT+1 pixel ticks (shift on pix_ce);
//     mixer registers rgb on the same tick, so all VGA outputs stay mutually aligned.
//   - Mixer: lowest-index opaque layer wins; none opaque -> BG_COLOR; de=0 -> rgb=0.
//   - Collision: pair (i,j), i<j, enumerated lexicographically (0,1)=bit0,(0,2)=bit1...
//     While delayed de=1, accumulator |= opaque_i&opaque_j per pair.
//   - On falling edge of delayed vertical-active (after last active line): collision_bits
//     <= accumulator, collision_valid pulses 1 clock, accumulator cleared same clock.
//     Accumulation and clear in same tick: clear wins, new hit goes to next frame.
//   - enable low: divider, h, v, delay line, accumulator cleared synchronously; outputs take
//     reset values except collision_bits, which holds. Restart from (0,0) on enable high.
//   - Reset mid-frame: immediate return to reset values; no partial collision report.
//   - Counters 11 bits; H_TOTAL, V_TOTAL must be <= 2048 (elaboration-time check).
// TESTING
//   1 Defaults, no layers opaque: hs low for 96 ticks starting 659 ticks after h=0
//     (656+3); vs low lines 490-491; frame period 420000 ticks; rgb=12'hF00 with de=1.
//   2 Layer0 and layer2 opaque at (100,100) only, colours 0x0F0/0x00F -> rgb 0x0F0 at that
//     pixel, 3 ticks after px_x=100,px_y=100; after frame collision_bits=6'b000010, pulse once.
//   3 Next frame no overlap -> collision_bits=0 reported; stale bits not retained.
//   4 CLK_DIV=3: pix_ce every 3rd clock; hs pulse width 288 clocks; frame 1260000 clocks.
//   5 HS_POL=1,VS_POL=1: reset hs=vs=0, pulses high; enable dropped mid-line -> outputs
//     idle next clock, restart with frame_start 3 ticks after enable high.
//   6 resetb low mid-frame during overlap -> all outputs reset, collision_valid never pulses.

Source files
------------

// File: rtl/vga_mixer_timing_gen.sv
// vga_mixer_timing_gen
//   VGA timing generator with an N-layer priority pixel mixer and per-frame
//   pairwise layer collision detection. Timing, sync polarity, pixel-clock
//   divide, layer count and colour width are all parameters.
//
// Ports
//   clock, resetb     system clock, asynchronous active-low reset
//   enable            run; low = synchronous hold at the origin
//   pix_ce            pixel tick strobe (one clock per pixel)
//   px_x, px_y        counter coordinates, valid while pix_ce is high
//   px_active         counters inside the active area (undelayed)
//   layer_opaque      per-layer opaque flags, LAYER_LAT ticks after px_x/px_y
//   layer_rgb         layer i colour at [i*RGB_W +: RGB_W]
//   vga_hs, vga_vs    sync outputs, asserted level HS_POL / VS_POL
//   vga_de            delayed data enable
//   vga_rgb           mixed pixel colour
//   frame_start       high for the tick that carries delayed pixel (0,0)
//   collision_bits    layer pairs that overlapped in the last completed frame
//   collision_valid   one-clock pulse when collision_bits updates
//
// Handshake: there is none; layer sources must answer px_x/px_y exactly
// LAYER_LAT pixel ticks later, and every VGA output is aligned to that.
module vga_mixer_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int N_LAYERS  = 4,
    parameter int RGB_W     = 12,
    parameter int LAYER_LAT = 2,
    parameter logic [RGB_W-1:0] BG_COLOR = 12'hF00,
    localparam int NPAIRS   = N_LAYERS * (N_LAYERS - 1) / 2
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic                      enable,
    output logic                      pix_ce,
    output logic [10:0]               px_x,
    output logic [10:0]               px_y,
    output logic                      px_active,
    input  logic [N_LAYERS-1:0]       layer_opaque,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      vga_de,
    output logic [RGB_W-1:0]          vga_rgb,
    output logic                      frame_start,
    output logic [NPAIRS-1:0]         collision_bits,
    output logic                      collision_valid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PIPE    = LAYER_LAT + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_mixer_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counters");
    end
    if (CLK_DIV < 1 || N_LAYERS < 2 || N_LAYERS > 8 || LAYER_LAT < 0) begin : g_bad_cfg
        $error("vga_mixer_timing_gen: illegal CLK_DIV/N_LAYERS/LAYER_LAT");
    end

    logic [DIV_W-1:0]  div;
    logic [10:0]       h, v;
    logic [NPAIRS-1:0] accum;

    // Delay lines hold sync/enable in asserted-high form; polarity is applied
    // only at the pins so an all-zero pipeline is the idle state.
    logic [PIPE-1:0] hs_p, vs_p, de_p, va_p, fs_p;
    // Chain element k = value k ticks ago (element 0 = undelayed counters).
    logic [PIPE:0]   hs_c, vs_c, de_c, va_c, fs_c;

    logic              hs_raw, vs_raw, va_raw, fs_raw;
    logic [RGB_W-1:0]  mix_rgb;
    logic [NPAIRS-1:0] pair_hits;
    logic              va_fall;

    assign px_x      = h;
    assign px_y      = v;
    assign va_raw    = (v < V_ACT);
    assign px_active = (h < H_ACT) && va_raw;
    assign hs_raw    = (h >= HS_START) && (h < HS_END);
    assign vs_raw    = (v >= VS_START) && (v < VS_END);
    assign fs_raw    = (h == 11'd0) && (v == 11'd0);

    assign hs_c = {hs_p, hs_raw};
    assign vs_c = {vs_p, vs_raw};
    assign de_c = {de_p, px_active};
    assign va_c = {va_p, va_raw};
    assign fs_c = {fs_p, fs_raw};

    // Element LAYER_LAT is the pixel the layer inputs currently describe;
    // vertical-active falls when the first line past the active area arrives.
    assign va_fall = va_c[LAYER_LAT+1] && !va_c[LAYER_LAT];

    // Lowest index wins: scan from the top so lower layers overwrite.
    always_comb begin
        mix_rgb = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_opaque[i]) mix_rgb = layer_rgb[i*RGB_W +: RGB_W];
        end
    end

    // Pair (i,j), i<j, sits at bit i*N - i*(i+1)/2 + (j-i-1).
    always_comb begin
        pair_hits = '0;
        for (int i = 0; i < N_LAYERS - 1; i++) begin
            for (int j = i + 1; j < N_LAYERS; j++) begin
                pair_hits[i*N_LAYERS - i*(i+1)/2 + (j-i-1)] = layer_opaque[i] & layer_opaque[j];
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div             <= '0;
            pix_ce          <= 1'b0;
            h               <= '0;
            v               <= '0;
            hs_p            <= '0;
            vs_p            <= '0;
            de_p            <= '0;
            va_p            <= '0;
            fs_p            <= '0;
            vga_rgb         <= '0;
            accum           <= '0;
            collision_bits  <= '0;
            collision_valid <= 1'b0;
        end else if (!enable) begin
            // Hold at the origin; the last collision report stays visible.
            div             <= '0;
            pix_ce          <= 1'b0;
            h               <= '0;
            v               <= '0;
            hs_p            <= '0;
            vs_p            <= '0;
            de_p            <= '0;
            va_p            <= '0;
            fs_p            <= '0;
            vga_rgb         <= '0;
            accum           <= '0;
            collision_valid <= 1'b0;
        end else begin
            collision_valid <= 1'b0;
            if (div == DIV_LAST) begin
                div    <= '0;
                pix_ce <= 1'b1;
            end else begin
                div    <= div + 1'b1;
                pix_ce <= 1'b0;
            end

            if (pix_ce) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
                end else begin
                    h <= h + 11'd1;
                end

                hs_p <= hs_c[PIPE-1:0];
                vs_p <= vs_c[PIPE-1:0];
                de_p <= de_c[PIPE-1:0];
                va_p <= va_c[PIPE-1:0];
                fs_p <= fs_c[PIPE-1:0];

                vga_rgb <= de_c[LAYER_LAT] ? mix_rgb : '0;

                // Report and clear take priority over accumulating this tick.
                if (va_fall) begin
                    collision_bits  <= accum;
                    collision_valid <= 1'b1;
                    accum           <= '0;
                end else if (de_c[LAYER_LAT]) begin
                    accum <= accum | pair_hits;
                end
            end
        end
    end

    assign vga_hs      = hs_p[PIPE-1] ? HS_POL : ~HS_POL;
    assign vga_vs      = vs_p[PIPE-1] ? VS_POL : ~VS_POL;
    assign vga_de      = de_p[PIPE-1];
    assign frame_start = fs_p[PIPE-1];

endmodule

// File: tb/tb_vga_mixer_timing_gen.sv
module tb_vga_mixer_timing_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 25
  localparam int VT = VA + VFP + VSW + VBP;   // 13
  localparam int FT = HT * VT;                // 325 ticks per frame
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int DIV = 2;
  localparam int NL = 4;
  localparam int RW = 12;
  localparam int LAT = 2;
  localparam int NP = NL * (NL - 1) / 2;
  localparam logic [RW-1:0] BG = 12'hF00;
  localparam int MAXN = 4096;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetb = 1'b1;
  logic enable = 1'b0;
  always #5 clock = ~clock;

  logic              pix_ce, px_active;
  logic [10:0]       px_x, px_y;
  logic [NL-1:0]     layer_opaque;
  logic [NL*RW-1:0]  layer_rgb;
  logic              vga_hs, vga_vs, vga_de, frame_start, collision_valid;
  logic [RW-1:0]     vga_rgb;
  logic [NP-1:0]     collision_bits;

  vga_mixer_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CLK_DIV(DIV), .N_LAYERS(NL),
    .RGB_W(RW), .LAYER_LAT(LAT), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .resetb(resetb), .enable(enable),
    .pix_ce(pix_ce), .px_x(px_x), .px_y(px_y), .px_active(px_active),
    .layer_opaque(layer_opaque), .layer_rgb(layer_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .collision_bits(collision_bits),
    .collision_valid(collision_valid)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int e_cnt = 0;          // clock edges seen with the block running
  int mode = 0;           // 1 = directed single-pixel overlap, 0 = random
  logic [NL-1:0]    op_arr  [MAXN];
  logic [NL*RW-1:0] col_arr [MAXN];
  logic [NP-1:0]    exp_bits = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int hof(input int n); return n % HT; endfunction
  function automatic int vof(input int n); return (n / HT) % VT; endfunction
  function automatic bit act_of(input int n); return (hof(n) < HA) && (vof(n) < VA); endfunction

  function automatic logic [RW-1:0] mix_of(input int m);
    for (int i = 0; i < NL; i++)
      if (op_arr[m][i]) return col_arr[m][i*RW +: RW];
    return BG;
  endfunction

  // Pairs enumerated (0,1),(0,2),...,(1,2),... over the active pixels of one frame.
  function automatic logic [NP-1:0] frame_hits(input int base);
    logic [NP-1:0] r;
    int p;
    r = '0;
    for (int idx = base; idx < base + VA * HT; idx++) begin
      if (hof(idx) < HA) begin
        p = 0;
        for (int i = 0; i < NL; i++)
          for (int j = i + 1; j < NL; j++) begin
            if (op_arr[idx][i] && op_arr[idx][j]) r[p] = 1'b1;
            p++;
          end
      end
    end
    return r;
  endfunction

  // Layer data for the pixel at tick n (created when that pixel is addressed).
  task automatic gen_data(input int n);
    logic [NL-1:0] op;
    logic [NL*RW-1:0] col;
    int r, a, b;
    col = {$urandom, $urandom};
    op = '0;
    if (mode == 1) begin
      if (n < FT && hof(n) == 5 && vof(n) == 3) begin
        op = 4'b0101;
        col[0 +: RW] = 12'h0F0;
        col[2*RW +: RW] = 12'h00F;
      end
    end else begin
      r = $urandom_range(0, 255);
      if (r < 100) begin
        a = $urandom_range(0, NL - 1);
        op[a] = 1'b1;
      end else if (r < 103) begin
        a = $urandom_range(0, NL - 1);
        b = (a + $urandom_range(1, NL - 1)) % NL;
        op[a] = 1'b1;
        op[b] = 1'b1;
      end
    end
    op_arr[n] = op;
    col_arr[n] = col;
  endtask

  always @(posedge clock) begin
    if (!resetb || !enable) e_cnt <= 0;
    else e_cnt <= e_cnt + 1;
  end

  // ---------------- compare process + layer driver ----------------
  always @(negedge clock) begin
    int e, k_done, m, mm, n;
    bit exp_pce, exp_cv, exp_hs_a, exp_vs_a, exp_de, exp_fs;
    logic [RW-1:0] exp_rgb;
    e = resetb ? e_cnt : 0;
    if (!resetb) exp_bits = '0;

    exp_pce = (e > 0) && (e % DIV == 0);
    chk("pix_ce", pix_ce, exp_pce);

    k_done = (e >= 1) ? (e - 1) / DIV : 0;   // pixel ticks already clocked
    m = k_done - 1 - LAT;                      // pixel now on the VGA pins
    exp_hs_a = 0; exp_vs_a = 0; exp_de = 0; exp_fs = 0; exp_rgb = '0;
    if (m >= 0) begin
      exp_hs_a = (hof(m) >= HA + HFP) && (hof(m) < HA + HFP + HSW);
      exp_vs_a = (vof(m) >= VA + VFP) && (vof(m) < VA + VFP + VSW);
      exp_de   = act_of(m);
      exp_fs   = (hof(m) == 0) && (vof(m) == 0);
      exp_rgb  = exp_de ? mix_of(m) : '0;
    end
    chk("vga_hs", vga_hs, exp_hs_a ? HS_POL : !HS_POL);
    chk("vga_vs", vga_vs, exp_vs_a ? VS_POL : !VS_POL);
    chk("vga_de", vga_de, exp_de);
    chk("frame_start", frame_start, exp_fs);
    chk("vga_rgb", vga_rgb, exp_rgb);

    // Report follows the tick that mixes pixel (0, VA) of a frame.
    mm = k_done - 1 - LAT;
    exp_cv = (e >= 1) && ((e - 1) % DIV == 0) && (mm + LAT >= 0) && (mm >= 0)
             && hof(mm) == 0 && vof(mm) == VA;
    if (exp_cv) exp_bits = frame_hits(mm - VA * HT);
    chk("collision_valid", collision_valid, exp_cv);
    chk("collision_bits", collision_bits, exp_bits);

    // Hand-computed anchors for the directed run (enable raised at tick 0).
    if (mode == 1 && resetb) begin
      if (e == 407)  begin chk("lit_cv_f0", collision_valid, 1); chk("lit_bits_f0", collision_bits, 6'b000010); end
      if (e == 408)  chk("lit_cv_once", collision_valid, 0);
      if (e == 1057) begin chk("lit_cv_f1", collision_valid, 1); chk("lit_bits_f1", collision_bits, 6'b000000); end
    end

    if (exp_pce) begin
      n = e / DIV - 1;
      chk("px_x", px_x, hof(n));
      chk("px_y", px_y, vof(n));
      chk("px_active", px_active, act_of(n));
      if (mode == 1) begin
        if (n == 3)   chk("lit_fs_first", frame_start, 1);
        if (n == 328) chk("lit_fs_period", frame_start, 1);
        if (n == 20)  chk("lit_hs_before", vga_hs, 1);
        if (n == 21)  chk("lit_hs_start", vga_hs, 0);
        if (n == 24)  chk("lit_hs_end", vga_hs, 1);
        if (n == 227) chk("lit_vs_before", vga_vs, 0);
        if (n == 228) chk("lit_vs_start", vga_vs, 1);
        if (n == 82)  chk("lit_rgb_bg", vga_rgb, 12'hF00);
        if (n == 83)  chk("lit_rgb_l0", vga_rgb, 12'h0F0);
      end
      if (n < MAXN) begin
        gen_data(n);
        if (n >= LAT) begin
          layer_opaque = op_arr[n - LAT];
          layer_rgb = col_arr[n - LAT];
        end else begin
          layer_opaque = NL'($urandom);
          layer_rgb = {$urandom, $urandom};
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_clocks(input int c);
    repeat (c) @(negedge clock);
    #1;
  endtask

  initial begin
    layer_opaque = '0;
    layer_rgb = '0;
    #1 resetb = 1'b0;
    run_clocks(4);
    resetb = 1'b1;
    run_clocks(3);

    // Directed overlap in frame 0, clean frame 1.
    mode = 1;
    enable = 1'b1;
    run_clocks(2 * FT * DIV + 60);

    // Random layers over several frames.
    enable = 1'b0;
    run_clocks(4);
    mode = 0;
    enable = 1'b1;
    run_clocks(4 * FT * DIV + $urandom_range(0, 40));

    // Enable dropped mid-line, then restart.
    enable = 1'b0;
    run_clocks($urandom_range(1, 6));
    enable = 1'b1;
    run_clocks(FT * DIV + 2 * HT * DIV + $urandom_range(2, 30));
    enable = 1'b0;
    run_clocks(3);
    enable = 1'b1;
    run_clocks(2 * FT * DIV + 20);

    // Reset inside the active area of the second frame, before its report.
    enable = 1'b0;
    run_clocks(2);
    enable = 1'b1;
    run_clocks(FT * DIV + $urandom_range(100, 300));
    resetb = 1'b0;
    run_clocks(3);
    resetb = 1'b1;
    run_clocks(FT * DIV + FT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
